// File: rtl/tick_countdown_if.sv
// Control and status bundle for tick_countdown: time-base controls, tick outputs
// and the countdown command/status signals.
interface tick_countdown_if #(
    parameter int unsigned STAGES = 4,
    parameter int unsigned CNT_W  = 12
);
    localparam int unsigned SEL_W = (STAGES > 1) ? $clog2(STAGES) : 1;

    logic              en;
    logic              clr;
    logic [STAGES-1:0] tick;
    logic [SEL_W-1:0]  sel;
    logic [CNT_W-1:0]  load_val;
    logic              start;
    logic              stop;
    logic              abort;
    logic [CNT_W-1:0]  remaining;
    logic              busy;
    logic              done;

    modport master (
        output en, clr, sel, load_val, start, stop, abort,
        input  tick, remaining, busy, done
    );

    modport slave (
        input  en, clr, sel, load_val, start, stop, abort,
        output tick, remaining, busy, done
    );
endinterface

// File: rtl/tick_countdown.sv
// Prescaled time base with a cascade of slower tick stages, plus a countdown channel
// that decrements a loaded value on a selectable tick.
module tick_countdown #(
    parameter int unsigned CLK_DIV   = 50000,
    parameter int unsigned STAGES    = 4,
    parameter int unsigned STAGE_DIV = 10,
    parameter int unsigned CNT_W     = 12
) (
    input  logic              clk,
    input  logic              rst_n,
    tick_countdown_if.slave   bus
);
    localparam int unsigned PC_W  = $clog2(CLK_DIV);
    localparam int unsigned SC_W  = $clog2(STAGE_DIV);
    localparam int unsigned SEL_W = (STAGES > 1) ? $clog2(STAGES) : 1;
    localparam int unsigned NSC   = (STAGES > 1) ? STAGES - 1 : 1;

    localparam logic [PC_W-1:0]  PC_MAX  = PC_W'(CLK_DIV - 1);
    localparam logic [SC_W-1:0]  SC_MAX  = SC_W'(STAGE_DIV - 1);
    localparam logic [SEL_W-1:0] SEL_MAX = SEL_W'(STAGES - 1);

    typedef enum logic [1:0] {StIdle, StRun, StPause} state_e;

    logic [PC_W-1:0]   pc_q, pc_d;
    logic [SC_W-1:0]   sc_q [NSC];
    logic [SC_W-1:0]   sc_d [NSC];
    logic [STAGES-1:0] s;
    logic [STAGES-1:0] tick_q;

    state_e            state_q, state_d;
    logic [CNT_W-1:0]  rem_q, rem_d;
    logic [SEL_W-1:0]  sel_q, sel_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic [SEL_W-1:0]  sel_clamped;
    logic              cd_strobe;

    // Time base: strobes already carry en and clr, so everything downstream is frozen too.
    always_comb begin
        pc_d = pc_q;
        if (bus.clr) begin
            pc_d = '0;
        end else if (bus.en) begin
            pc_d = (pc_q == PC_MAX) ? '0 : pc_q + 1'b1;
        end
    end

    always_comb begin
        s     = '0;
        sc_d  = sc_q;
        s[0]  = bus.en & ~bus.clr & (pc_q == PC_MAX);
        for (int k = 0; k < int'(STAGES) - 1; k++) begin
            if (s[k]) begin
                sc_d[k] = (sc_q[k] == SC_MAX) ? '0 : sc_q[k] + 1'b1;
            end
            s[k+1] = s[k] & (sc_q[k] == SC_MAX);
        end
        if (bus.clr) begin
            for (int k = 0; k < int'(NSC); k++) begin
                sc_d[k] = '0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_q   <= '0;
            tick_q <= '0;
            for (int k = 0; k < int'(NSC); k++) begin
                sc_q[k] <= '0;
            end
        end else begin
            pc_q   <= pc_d;
            tick_q <= s;
            sc_q   <= sc_d;
        end
    end

    assign sel_clamped = (bus.sel > SEL_MAX) ? SEL_MAX : bus.sel;
    assign cd_strobe   = s[sel_q];

    // Priority: abort > stop > start > strobe.
    always_comb begin
        state_d = state_q;
        rem_d   = rem_q;
        sel_d   = sel_q;
        done_d  = 1'b0;
        if (bus.abort) begin
            state_d = StIdle;
            rem_d   = '0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (bus.start) begin
                        if (bus.load_val != '0) begin
                            state_d = StRun;
                            rem_d   = bus.load_val;
                            sel_d   = sel_clamped;
                        end else begin
                            done_d = 1'b1;
                        end
                    end
                end
                StRun: begin
                    if (bus.stop) begin
                        state_d = StPause;
                    end else if (cd_strobe) begin
                        if (rem_q == CNT_W'(1)) begin
                            rem_d   = '0;
                            done_d  = 1'b1;
                            state_d = StIdle;
                        end else begin
                            rem_d = rem_q - 1'b1;
                        end
                    end
                end
                StPause: begin
                    if (bus.start) begin
                        state_d = StRun;
                    end
                end
                default: begin
                    state_d = StIdle;
                    rem_d   = '0;
                end
            endcase
        end
        busy_d = (state_d != StIdle);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            rem_q   <= '0;
            sel_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            rem_q   <= rem_d;
            sel_q   <= sel_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign bus.tick      = tick_q;
    assign bus.remaining = rem_q;
    assign bus.busy      = busy_q;
    assign bus.done      = done_q;
endmodule

// File: tb/tb_tick_countdown.sv
// Directed bench for tick_countdown with small divide ratios (4 / 3 / 3 stages).
module tb_tick_countdown;
    localparam int unsigned CLK_DIV   = 4;
    localparam int unsigned STAGES    = 3;
    localparam int unsigned STAGE_DIV = 3;
    localparam int unsigned CNT_W     = 12;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   n_checks = 0;
    int   n_fail   = 0;

    tick_countdown_if #(.STAGES(STAGES), .CNT_W(CNT_W)) bus ();

    tick_countdown #(
        .CLK_DIV   (CLK_DIV),
        .STAGES    (STAGES),
        .STAGE_DIV (STAGE_DIV),
        .CNT_W     (CNT_W)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Clear the time base and issue start on the same edge (call it E0).
    task automatic sync_start(input logic [CNT_W-1:0] lv, input logic [1:0] sl);
        bus.clr      = 1'b1;
        bus.start    = 1'b1;
        bus.load_val = lv;
        bus.sel      = sl;
        step(1);
        bus.clr   = 1'b0;
        bus.start = 1'b0;
    endtask

    initial begin
        logic [2:0] exp_t;
        bus.en = 1'b0; bus.clr = 1'b0; bus.sel = '0; bus.load_val = '0;
        bus.start = 1'b0; bus.stop = 1'b0; bus.abort = 1'b0;
        step(3);
        check("rst_tick", 32'(bus.tick), 0);
        check("rst_rem", 32'(bus.remaining), 0);
        check("rst_busy", 32'(bus.busy), 0);
        check("rst_done", 32'(bus.done), 0);

        // Free-running cascade from reset release.
        rst_n  = 1'b1;
        bus.en = 1'b1;
        for (int n = 1; n <= 40; n++) begin
            step(1);
            exp_t = {n % 36 == 0, n % 12 == 0, n % 4 == 0};
            check("tick_run", 32'(bus.tick), 32'(exp_t));
        end

        // Freeze for 5 edges mid-period: ticks stretch by 5.
        step(2);
        bus.en = 1'b0;
        for (int n = 43; n <= 47; n++) begin
            step(1);
            check("tick_frozen", 32'(bus.tick), 0);
        end
        bus.en = 1'b1;
        for (int n = 48; n <= 53; n++) begin
            step(1);
            exp_t = {1'b0, n == 53, n == 49 || n == 53};
            check("tick_stretch", 32'(bus.tick), 32'(exp_t));
        end

        // clr on the edge that would have produced a tick.
        step(3);
        bus.clr = 1'b1;
        step(1);
        check("tick_clr", 32'(bus.tick), 0);
        bus.clr = 1'b0;
        for (int i = 1; i <= 4; i++) begin
            step(1);
            check("tick_after_clr", 32'(bus.tick), (i == 4) ? 1 : 0);
        end

        // Countdown 3 on tick[1].
        sync_start(12'd3, 2'd1);
        check("cd1_busy", 32'(bus.busy), 1);
        check("cd1_rem3", 32'(bus.remaining), 3);
        step(11);
        check("cd1_rem3_hold", 32'(bus.remaining), 3);
        step(1);
        check("cd1_rem2", 32'(bus.remaining), 2);
        check("cd1_tick12", 32'(bus.tick), 3);
        step(12);
        check("cd1_rem1", 32'(bus.remaining), 1);
        step(11);
        check("cd1_rem1_hold", 32'(bus.remaining), 1);
        check("cd1_no_done", 32'(bus.done), 0);
        step(1);
        check("cd1_rem0", 32'(bus.remaining), 0);
        check("cd1_done", 32'(bus.done), 1);
        check("cd1_busy0", 32'(bus.busy), 0);
        check("cd1_tick36", 32'(bus.tick), 7);
        step(1);
        check("cd1_done_width", 32'(bus.done), 0);

        // Countdown 5 on tick[0] with a 20-cycle pause.
        sync_start(12'd5, 2'd0);
        step(4);
        check("cd2_rem4", 32'(bus.remaining), 4);
        step(4);
        check("cd2_rem3", 32'(bus.remaining), 3);
        bus.stop = 1'b1;
        step(1);
        bus.stop = 1'b0;
        step(20);
        check("cd2_pause_rem", 32'(bus.remaining), 3);
        check("cd2_pause_busy", 32'(bus.busy), 1);
        bus.start = 1'b1;
        step(1);
        bus.start = 1'b0;
        check("cd2_resume_rem", 32'(bus.remaining), 3);
        step(2);
        check("cd2_rem2", 32'(bus.remaining), 2);
        step(4);
        check("cd2_rem1", 32'(bus.remaining), 1);
        step(3);
        check("cd2_no_done", 32'(bus.done), 0);
        step(1);
        check("cd2_rem0", 32'(bus.remaining), 0);
        check("cd2_done", 32'(bus.done), 1);
        check("cd2_busy0", 32'(bus.busy), 0);

        // Zero load: immediate done, never busy.
        bus.load_val = '0;
        bus.start    = 1'b1;
        step(1);
        bus.start = 1'b0;
        check("zero_done", 32'(bus.done), 1);
        check("zero_busy", 32'(bus.busy), 0);
        step(1);
        check("zero_done_width", 32'(bus.done), 0);

        // Abort with remaining = 4.
        sync_start(12'd5, 2'd0);
        step(4);
        check("abort_pre_rem", 32'(bus.remaining), 4);
        bus.abort = 1'b1;
        step(1);
        bus.abort = 1'b0;
        check("abort_rem", 32'(bus.remaining), 0);
        check("abort_busy", 32'(bus.busy), 0);
        for (int i = 0; i < 4; i++) begin
            step(1);
            check("abort_no_done", 32'(bus.done), 0);
        end

        // stop coinciding with the expiring strobe wins.
        sync_start(12'd2, 2'd0);
        step(4);
        check("stopx_rem1", 32'(bus.remaining), 1);
        step(3);
        bus.stop = 1'b1;
        step(1);
        bus.stop = 1'b0;
        check("stopx_rem", 32'(bus.remaining), 1);
        check("stopx_done", 32'(bus.done), 0);
        check("stopx_busy", 32'(bus.busy), 1);
        step(4);
        check("stopx_hold", 32'(bus.remaining), 1);
        bus.start = 1'b1;
        step(1);
        bus.start = 1'b0;
        check("stopx_resumed", 32'(bus.busy), 1);

        // Asynchronous reset mid-run.
        #2;
        rst_n = 1'b0;
        #1;
        check("arst_rem", 32'(bus.remaining), 0);
        check("arst_busy", 32'(bus.busy), 0);
        check("arst_done", 32'(bus.done), 0);
        check("arst_tick", 32'(bus.tick), 0);
        step(1);
        rst_n = 1'b1;

        // sel beyond range clamps to the slowest stage.
        sync_start(12'd1, 2'd3);
        check("clamp_busy", 32'(bus.busy), 1);
        step(12);
        check("clamp_rem_t12", 32'(bus.remaining), 1);
        step(23);
        check("clamp_rem_t35", 32'(bus.remaining), 1);
        step(1);
        check("clamp_rem0", 32'(bus.remaining), 0);
        check("clamp_done", 32'(bus.done), 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
